// File: rtl/dsram_like_bridge.sv
// SRAM-style core data port to sram-like (req/addr_ok/data_ok) bridge.
// Optional flush/drain support is enabled with `define DSRAM_BRIDGE_FLUSH_EN.
module dsram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DSRAM_BRIDGE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  input  logic              longest_stall,
  output logic              d_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state, w_next;
  logic              r_rd;
  logic [DATA_W-1:0] r_rdata;
  logic              w_flush;
  logic              w_latch;
  logic              w_is_rd;
  logic [1:0]        w_size;
  logic [1:0]        w_off;

`ifdef DSRAM_BRIDGE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_is_rd = ~|data_sram_wen;

  // Only contiguous, naturally aligned byte/half patterns get a narrow size.
  always_comb begin
    w_size = 2'd2;
    w_off  = 2'd0;
    case (data_sram_wen)
      4'b0011: begin w_size = 2'd1; w_off = 2'd0; end
      4'b1100: begin w_size = 2'd1; w_off = 2'd2; end
      4'b0001: begin w_size = 2'd0; w_off = 2'd0; end
      4'b0010: begin w_size = 2'd0; w_off = 2'd1; end
      4'b0100: begin w_size = 2'd0; w_off = 2'd2; end
      4'b1000: begin w_size = 2'd0; w_off = 2'd3; end
      default: begin w_size = 2'd2; w_off = 2'd0; end
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_flush && data_sram_en && data_addr_ok) begin
          if (data_data_ok) begin
            w_next  = S_HOLD;
            w_latch = w_is_rd;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
`ifdef DSRAM_BRIDGE_FLUSH_EN
        // A flush coinciding with data_ok retires the access and discards it.
        if (w_flush) begin
          w_next = data_data_ok ? S_IDLE : S_DRAIN;
        end else
`endif
        if (data_data_ok) begin
          w_next  = S_HOLD;
          w_latch = r_rd;
        end
      end
      S_HOLD: begin
        if (w_flush || !longest_stall) w_next = S_IDLE;
      end
`ifdef DSRAM_BRIDGE_FLUSH_EN
      S_DRAIN: begin
        if (data_data_ok) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rd    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_rd <= w_is_rd;
      if (w_latch) r_rdata <= data_rdata;
    end
  end

  assign data_sram_rdata = r_rdata;
  assign data_req   = data_sram_en && (r_state == S_IDLE) && !w_flush;
  assign d_stall    = (data_sram_en && (r_state != S_HOLD)) || (r_state == S_DRAIN);
  assign data_wr    = ~w_is_rd;
  assign data_size  = w_size;
  assign data_addr  = (data_sram_addr & ~ADDR_W'(3)) | ADDR_W'(w_off);
  assign data_wdata = data_sram_wdata;

endmodule
